// File: rtl/rf_black_widow_insn_queue_pkg.sv
// rtl/rf_black_widow_insn_queue_pkg.sv - shared types and constants for the instruction queue
package rfBlackWidowPkg;

    localparam int QDEPTH_DEFAULT = 8;
    localparam int INSN_W         = 40;
    localparam int ADDR_W         = 32;

    typedef logic [INSN_W-1:0] Instruction;
    typedef logic [ADDR_W-1:0] Address;
    typedef logic [6:0]        Opcode;

    typedef struct packed {
        Instruction ins;
        Address     pc;
    } InsnQueueEntry;

    localparam Opcode OP_ADD  = 7'h01;
    localparam Opcode OP_ADDI = 7'h04;
    localparam Opcode OP_ORI  = 7'h05;
    localparam Opcode OP_LDO  = 7'h10;
    localparam Opcode OP_CON1 = 7'h50;
    localparam Opcode OP_CON2 = 7'h51;
    localparam Opcode OP_CON3 = 7'h52;
    localparam Opcode OP_NOP  = 7'h3F;

    localparam Instruction NOP_INSN = {33'd0, OP_NOP};

    // Opcode lives in the low seven bits of every instruction.
    function automatic Opcode get_op(input Instruction ins);
        return ins[6:0];
    endfunction

endpackage

// File: rtl/rf_black_widow_insn_queue_postfix_count.sv
// rtl/rf_black_widow_insn_queue_postfix_count.sv - CON postfix chain length and window-valid decode
module rf_black_widow_postfix_count
    import rfBlackWidowPkg::*;
#(
    parameter int CW = 4
) (
    input  Opcode         op1_i,
    input  Opcode         op2_i,
    input  Opcode         op3_i,
    input  logic [CW-1:0] count_i,
    output logic [1:0]    n_o,
    output logic          win_v_o
);

    logic has1, has2, has3;

    always_comb begin
        has1 = (count_i >= CW'(2)) && (op1_i == OP_CON1);
        has2 = has1 && (count_i >= CW'(3)) && (op2_i == OP_CON2);
        has3 = has2 && (count_i >= CW'(4)) && (op3_i == OP_CON3);
        n_o  = has3 ? 2'd3 : has2 ? 2'd2 : has1 ? 2'd1 : 2'd0;
        // A chain shorter than three needs one trailing entry to prove it has ended.
        win_v_o = (count_i >= (CW'(n_o) + CW'(2))) || has3;
    end

endmodule

// File: rtl/rf_black_widow_insn_queue.sv
// rtl/rf_black_widow_insn_queue.sv - dual-enqueue instruction queue presenting a postfix-aware decode window
module rf_black_widow_insn_queue
    import rfBlackWidowPkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic [1:0] ins_v_i,
    input  Instruction ins0_i,
    input  Instruction ins1_i,
    input  Address     pc0_i,
    input  Address     pc1_i,
    output logic       rdy_o,
    input  logic       dec_rdy_i,
    output logic       win_v_o,
    output Instruction ir_o,
    output Instruction ir1_o,
    output Instruction ir2_o,
    output Instruction ir3_o,
    output Address     pc_o,
    output logic [1:0] npfx_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    InsnQueueEntry mem [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    InsnQueueEntry e0, e1, e2, e3;
    logic [1:0]    n, nin;
    logic [2:0]    adv;
    logic          win_v, deq;

    always_comb begin
        e0 = mem[head];
        e1 = mem[head + PW'(1)];
        e2 = mem[head + PW'(2)];
        e3 = mem[head + PW'(3)];
    end

    rf_black_widow_postfix_count #(.CW(CW)) u_pfx (
        .op1_i   (get_op(e1.ins)),
        .op2_i   (get_op(e2.ins)),
        .op3_i   (get_op(e3.ins)),
        .count_i (count),
        .n_o     (n),
        .win_v_o (win_v)
    );

    always_comb begin
        rdy_o = (CW'(QDEPTH) - count) >= CW'(2);
        nin   = 2'd0;
        // Slot 1 without slot 0 is not a legal fetch pattern and is dropped.
        if (rdy_o && ins_v_i[0])
            nin = ins_v_i[1] ? 2'd2 : 2'd1;
        deq = win_v && dec_rdy_i;
        adv = {1'b0, n} + 3'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(nin);
            head  <= deq ? head + PW'(adv) : head;
            count <= count + CW'(nin) - (deq ? CW'(adv) : CW'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            if (nin != 2'd0)
                mem[tail] <= '{ins: ins0_i, pc: pc0_i};
            if (nin == 2'd2)
                mem[tail + PW'(1)] <= '{ins: ins1_i, pc: pc1_i};
        end
    end

    always_comb begin
        win_v_o = win_v;
        ir_o    = win_v ? e0.ins : NOP_INSN;
        ir1_o   = (win_v && n >= 2'd1) ? e1.ins : NOP_INSN;
        ir2_o   = (win_v && n >= 2'd2) ? e2.ins : NOP_INSN;
        ir3_o   = (win_v && n == 2'd3) ? e3.ins : NOP_INSN;
        pc_o    = win_v ? e0.pc : '0;
        npfx_o  = win_v ? n : 2'd0;
    end

endmodule

// File: tb/tb_rf_black_widow_insn_queue.sv
// tb/tb_rf_black_widow_insn_queue.sv - directed self-checking bench for the instruction queue
module tb_rf_black_widow_insn_queue;
    import rfBlackWidowPkg::*;

    logic       clk = 1'b0;
    logic       rst_i, flush_i, dec_rdy_i;
    logic [1:0] ins_v_i;
    Instruction ins0_i, ins1_i;
    Address     pc0_i, pc1_i;
    logic       rdy_o, win_v_o;
    Instruction ir_o, ir1_o, ir2_o, ir3_o;
    Address     pc_o;
    logic [1:0] npfx_o;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    rf_black_widow_insn_queue #(.QDEPTH(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .ins_v_i   (ins_v_i),
        .ins0_i    (ins0_i),
        .ins1_i    (ins1_i),
        .pc0_i     (pc0_i),
        .pc1_i     (pc1_i),
        .rdy_o     (rdy_o),
        .dec_rdy_i (dec_rdy_i),
        .win_v_o   (win_v_o),
        .ir_o      (ir_o),
        .ir1_o     (ir1_o),
        .ir2_o     (ir2_o),
        .ir3_o     (ir3_o),
        .pc_o      (pc_o),
        .npfx_o    (npfx_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic Instruction mk(input Opcode op, input int tag);
        logic [32:0] t;
        t = 33'(tag);
        return {t, op};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        ins_v_i   = 2'b00;
        dec_rdy_i = 1'b0;
        flush_i   = 1'b0;
        rst_i     = 1'b0;
    endtask

    task automatic push(input logic [1:0] v, input Instruction i0, input Address p0,
                        input Instruction i1, input Address p1, input logic dr);
        ins_v_i = v; ins0_i = i0; pc0_i = p0; ins1_i = i1; pc1_i = p1; dec_rdy_i = dr;
        cyc();
    endtask

    task automatic idle(input logic dr);
        dec_rdy_i = dr;
        cyc();
    endtask

    task automatic do_flush(input logic [1:0] v, input logic dr);
        flush_i = 1'b1; ins_v_i = v; dec_rdy_i = dr;
        ins0_i = mk(OP_ADDI, 999); ins1_i = mk(OP_ADDI, 998);
        pc0_i = 32'hDEAD; pc1_i = 32'hBEEF;
        cyc();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".win_v"}, 64'(win_v_o), 64'd0);
        chk({tag, ".ir"},    64'(ir_o),    64'(NOP_INSN));
        chk({tag, ".ir1"},   64'(ir1_o),   64'(NOP_INSN));
        chk({tag, ".pc"},    64'(pc_o),    64'd0);
        chk({tag, ".npfx"},  64'(npfx_o),  64'd0);
    endtask

    Instruction a, b, c, d, e, ldo, con1, con2, con3, add, ori, x, y, z, w;
    Instruction fill [8];

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; dec_rdy_i = 1'b0; ins_v_i = 2'b00;
        ins0_i = '0; ins1_i = '0; pc0_i = '0; pc1_i = '0;
        @(posedge clk); #1;
        rst_i = 1'b1;
        cyc();
        chk("rst.rdy", 64'(rdy_o), 64'd1);
        chk_idle("rst");

        a = mk(OP_ADDI, 1); b = mk(OP_ADDI, 2); c = mk(OP_ADDI, 3);
        d = mk(OP_ADDI, 4); e = mk(OP_ADDI, 5);
        push(2'b11, a, 32'h100, b, 32'h105, 1'b1);
        chk("pair.win_v", 64'(win_v_o), 64'd1);
        chk("pair.ir",    64'(ir_o),    64'(a));
        chk("pair.pc",    64'(pc_o),    64'h100);
        chk("pair.npfx",  64'(npfx_o),  64'd0);
        chk("pair.ir1",   64'(ir1_o),   64'(NOP_INSN));
        idle(1'b1);
        chk_idle("lone");
        push(2'b01, c, 32'h10A, '0, '0, 1'b0);
        chk("third.ir", 64'(ir_o), 64'(b));
        chk("third.pc", 64'(pc_o), 64'h105);
        push(2'b11, d, 32'h10F, e, 32'h114, 1'b1);
        chk("simul.ir", 64'(ir_o), 64'(c));
        chk("simul.pc", 64'(pc_o), 64'h10A);
        do_flush(2'b00, 1'b0);
        chk_idle("flush0");

        ldo = mk(OP_LDO, 10); con1 = mk(OP_CON1, 11); con2 = mk(OP_CON2, 12);
        add = mk(OP_ADD, 13); con3 = mk(OP_CON3, 14); ori = mk(OP_ORI, 15);
        push(2'b11, ldo, 32'h300, con1, 32'h305, 1'b0);
        chk("ldo2.win_v", 64'(win_v_o), 64'd0);
        push(2'b11, con2, 32'h30A, add, 32'h314, 1'b0);
        chk("ldo4.win_v", 64'(win_v_o), 64'd1);
        chk("ldo4.npfx",  64'(npfx_o),  64'd2);
        chk("ldo4.ir",    64'(ir_o),    64'(ldo));
        chk("ldo4.ir1",   64'(ir1_o),   64'(con1));
        chk("ldo4.ir2",   64'(ir2_o),   64'(con2));
        chk("ldo4.ir3",   64'(ir3_o),   64'(NOP_INSN));
        chk("ldo4.pc",    64'(pc_o),    64'h300);
        idle(1'b1);
        chk("ldo.deq.win_v", 64'(win_v_o), 64'd0);
        push(2'b01, a, 32'h320, '0, '0, 1'b0);
        chk("ldo.deq.ir",   64'(ir_o),   64'(add));
        chk("ldo.deq.pc",   64'(pc_o),   64'h314);
        chk("ldo.deq.npfx", 64'(npfx_o), 64'd0);
        do_flush(2'b00, 1'b0);

        push(2'b11, con2, 32'h400, a, 32'h405, 1'b0);
        chk("conhead.ir",   64'(ir_o),   64'(con2));
        chk("conhead.npfx", 64'(npfx_o), 64'd0);
        do_flush(2'b00, 1'b0);
        push(2'b11, con1, 32'h410, con1, 32'h415, 1'b0);
        chk("con1con1.win_v", 64'(win_v_o), 64'd0);
        push(2'b01, a, 32'h41A, '0, '0, 1'b0);
        chk("con1con1.npfx", 64'(npfx_o), 64'd1);
        chk("con1con1.ir1",  64'(ir1_o),  64'(con1));
        chk("con1con1.ir2",  64'(ir2_o),  64'(NOP_INSN));
        do_flush(2'b00, 1'b0);

        push(2'b11, ori, 32'h500, con1, 32'h505, 1'b0);
        chk("ori2.win_v", 64'(win_v_o), 64'd0);
        push(2'b11, con2, 32'h50A, con3, 32'h50F, 1'b0);
        chk("ori4.win_v", 64'(win_v_o), 64'd1);
        chk("ori4.npfx",  64'(npfx_o),  64'd3);
        chk("ori4.ir",    64'(ir_o),    64'(ori));
        chk("ori4.ir3",   64'(ir3_o),   64'(con3));
        idle(1'b1);
        chk_idle("ori.deq");
        chk("ori.deq.rdy", 64'(rdy_o), 64'd1);

        // Head now sits mid-buffer, so filling eight entries wraps the tail.
        for (int k = 0; k < 8; k++) fill[k] = mk(OP_ADDI, 100 + k);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("fill%0d.rdy", 2 * p), 64'(rdy_o), 64'd1);
            push(2'b11, fill[2*p], 32'h200 + 32'(8 * p), fill[2*p+1], 32'h204 + 32'(8 * p), 1'b0);
        end
        chk("full8.rdy", 64'(rdy_o), 64'd0);
        x = mk(OP_ADDI, 777);
        push(2'b11, x, 32'h900, x, 32'h904, 1'b0);
        chk("full8.ir", 64'(ir_o), 64'(fill[0]));
        idle(1'b1);
        chk("full7.rdy", 64'(rdy_o), 64'd0);
        for (int k = 1; k < 7; k++) begin
            chk($sformatf("drain%0d.ir", k), 64'(ir_o), 64'(fill[k]));
            chk($sformatf("drain%0d.pc", k), 64'(pc_o), 64'(32'h200 + 32'(4 * k)));
            idle(1'b1);
        end
        chk("drain.last.win_v", 64'(win_v_o), 64'd0);
        y = mk(OP_ADDI, 200);
        push(2'b01, y, 32'h600, '0, '0, 1'b0);
        chk("drain.tail.ir", 64'(ir_o), 64'(fill[7]));

        do_flush(2'b11, 1'b1);
        chk_idle("flush11");
        chk("flush11.rdy", 64'(rdy_o), 64'd1);
        z = mk(OP_ADDI, 300); w = mk(OP_ADDI, 301);
        push(2'b01, z, 32'h700, '0, '0, 1'b0);
        chk("postflush1.win_v", 64'(win_v_o), 64'd0);
        push(2'b01, w, 32'h705, '0, '0, 1'b0);
        chk("postflush2.ir", 64'(ir_o), 64'(z));

        push(2'b10, x, 32'h800, x, 32'h804, 1'b0);
        chk("v10.ir", 64'(ir_o), 64'(z));
        idle(1'b1);
        chk("v10.win_v", 64'(win_v_o), 64'd0);

        push(2'b11, a, 32'h710, b, 32'h715, 1'b0);
        rst_i = 1'b1;
        cyc();
        chk_idle("midrst");
        chk("midrst.rdy", 64'(rdy_o), 64'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
